// File: rtl/bcd_convert_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | adc_pkg : shared constants and FSM encoding for the BCD arbiter   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package adc_pkg;

    localparam int DATA_W = 8;
    localparam int BCD_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_convert_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_convert_arbiter_if : requester and result handshake bundle    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface bcd_convert_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CHAN_W  = 2
);
    import adc_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      bcd_valid;
    logic                      bcd_ready;
    logic [BCD_W-1:0]          bcd_hundreds;
    logic [BCD_W-1:0]          bcd_tens;
    logic [BCD_W-1:0]          bcd_ones;
    logic [CHAN_W-1:0]         bcd_chan;
    logic                      busy;

    modport master (
        output req_valid, req_data, bcd_ready,
        input  req_ready, bcd_valid, bcd_hundreds, bcd_tens, bcd_ones, bcd_chan, busy
    );

    modport slave (
        input  req_valid, req_data, bcd_ready,
        output req_ready, bcd_valid, bcd_hundreds, bcd_tens, bcd_ones, bcd_chan, busy
    );

endinterface
`default_nettype wire

// File: rtl/bcd_convert_arbiter_bcd.sv
`default_nettype none
// +------------------------------------------------------------------+
// | binary_to_bcd : combinational 8-bit binary to 3-digit BCD         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module binary_to_bcd
    import adc_pkg::*;
(
    input  wire logic [DATA_W-1:0] i_bin,
    output logic      [BCD_W-1:0]  o_hundreds,
    output logic      [BCD_W-1:0]  o_tens,
    output logic      [BCD_W-1:0]  o_ones
);

    logic [3*BCD_W-1:0] w_digits;
    logic [DATA_W-1:0]  w_bin;

    // Double-dabble: correct each digit >= 5 before shifting the next bit in.
    always_comb begin
        w_digits = '0;
        w_bin    = i_bin;
        for (int i = 0; i < DATA_W; i++) begin
            if (w_digits[3:0] >= 4'd5) w_digits[3:0] = w_digits[3:0] + 4'd3;
            if (w_digits[7:4] >= 4'd5) w_digits[7:4] = w_digits[7:4] + 4'd3;
            w_digits = {w_digits[3*BCD_W-2:0], w_bin[DATA_W-1]};
            w_bin    = w_bin << 1;
        end
    end

    assign o_hundreds = w_digits[11:8];
    assign o_tens     = w_digits[7:4];
    assign o_ones     = w_digits[3:0];

endmodule
`default_nettype wire

// File: rtl/bcd_convert_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bcd_convert_arbiter : round-robin share of one binary_to_bcd unit |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module bcd_convert_arbiter
    import adc_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CHAN_W  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bcd_convert_arbiter_if.slave  bus
);

    localparam logic [CHAN_W-1:0] c_LAST_CHAN = CHAN_W'(NUM_REQ - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CHAN_W-1:0]   r_rr_ptr;
    logic [CHAN_W-1:0]   r_chan_q;
    logic [DATA_W-1:0]   r_data_q;
    logic [BCD_W-1:0]    r_hundreds;
    logic [BCD_W-1:0]    r_tens;
    logic [BCD_W-1:0]    r_ones;
    logic [CHAN_W-1:0]   r_chan_out;
    logic                r_bcd_valid;

    logic                w_grant_found;
    logic [CHAN_W-1:0]   w_grant_idx;
    logic [DATA_W-1:0]   w_grant_data;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [BCD_W-1:0]    w_hundreds;
    logic [BCD_W-1:0]    w_tens;
    logic [BCD_W-1:0]    w_ones;
    int                  w_idx;

    // Search starts at rr_ptr and wraps at NUM_REQ, so unused codes are never visited.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_grant_data  = '0;
        w_idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_grant_found && bus.req_valid[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = CHAN_W'(w_idx);
                w_grant_data  = bus.req_data[w_idx*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_found) begin
                    w_state_next             = ST_CONVERT;
                    w_req_ready[w_grant_idx] = 1'b1;
                end
            end
            ST_CONVERT: w_state_next = ST_HOLD;
            ST_HOLD: begin
                if (bus.bcd_ready) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_chan_q    <= '0;
            r_data_q    <= '0;
            r_hundreds  <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_chan_out  <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_found) begin
                        r_data_q <= w_grant_data;
                        r_chan_q <= w_grant_idx;
                    end
                end
                ST_CONVERT: begin
                    r_hundreds  <= w_hundreds;
                    r_tens      <= w_tens;
                    r_ones      <= w_ones;
                    r_chan_out  <= r_chan_q;
                    r_bcd_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (bus.bcd_ready) begin
                        r_bcd_valid <= 1'b0;
                        r_rr_ptr    <= (r_chan_q == c_LAST_CHAN) ? '0 : r_chan_q + CHAN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    binary_to_bcd u_bcd (
        .i_bin      (r_data_q),
        .o_hundreds (w_hundreds),
        .o_tens     (w_tens),
        .o_ones     (w_ones)
    );

    // Grant is combinational, so mask it while reset holds the FSM.
    assign bus.req_ready    = rst ? '0 : w_req_ready;
    assign bus.bcd_valid    = r_bcd_valid;
    assign bus.bcd_hundreds = r_hundreds;
    assign bus.bcd_tens     = r_tens;
    assign bus.bcd_ones     = r_ones;
    assign bus.bcd_chan     = r_chan_out;
    assign bus.busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire
